// File: rtl/wb_frame_reader_if.sv
// wshb_if: Wishbone classic bus bundle, clock and reset included.
//   clk, rst : bus clock and synchronous active-high reset (interface ports)
//   cyc, stb : bus cycle / strobe (master -> slave)
//   we, sel  : write enable / byte selects (master -> slave)
//   adr      : byte address (master -> slave)
//   ms       : write data (master -> slave)
//   sm       : read data (slave -> master)
//   ack, err, rty : transfer termination (slave -> master)
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] ms;
   logic [31:0] sm;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      input  clk, rst, sm, ack, err, rty,
      output cyc, stb, we, sel, adr, ms
   );

   modport slave (
      input  clk, rst, cyc, stb, we, sel, adr, ms,
      output sm, ack, err, rty
   );
endinterface

// File: rtl/wb_frame_reader.sv
// wb_frame_reader: Wishbone classic read master that walks a framebuffer
// (HDISP x VDISP words starting at BASE_ADR) forever while enabled and
// streams the pixels out through a first-word-fall-through FIFO.
//   wb_m       : Wishbone master port (clk/rst carried by the interface)
//   en         : allows new read requests
//   pix_data   : RGB pixel, sm[23:0] of the read word
//   pix_valid  : FIFO not empty
//   pix_ready  : consumer accepts the current pixel
//   pix_sof    : current pixel is (0,0)
//   pix_eol    : current pixel is the last one of its line
//   fifo_level : registered FIFO occupancy
module wb_frame_reader #(
   parameter int unsigned HDISP      = 800,
   parameter int unsigned VDISP      = 480,
   parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 16
) (
   wshb_if.master                    wb_m,
   input  logic                      en,
   output logic [23:0]               pix_data,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic                      pix_sof,
   output logic                      pix_eol,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = PW + 1;

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [31:0]     adr_q, adr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [25:0]     mem_q [FIFO_DEPTH];

   logic            push;
   logic            pop;
   logic            last_x;
   logic            last_y;
   logic [25:0]     push_entry;

   assign last_x     = (x_q == XW'(HDISP - 1));
   assign last_y     = (y_q == YW'(VDISP - 1));
   assign push_entry = {(x_q == '0) && (y_q == '0), last_x, wb_m.sm[23:0]};
   assign pop        = (level_q != '0) && pix_ready;

   // Next-state / counter logic. adr_q is kept equal to
   // BASE_ADR + 4*(y*HDISP + x) by stepping it alongside x/y, so no
   // multiplier is needed; it restarts at BASE_ADR on frame wrap.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      adr_d   = adr_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en && (level_q < LW'(FIFO_DEPTH))) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (wb_m.ack) begin
               // ack has priority over a simultaneous err/rty
               push    = 1'b1;
               state_d = IDLE;
               adr_d   = adr_q + 32'd4;
               if (last_x) begin
                  x_d = '0;
                  if (last_y) begin
                     y_d   = '0;
                     adr_d = BASE_ADR;
                  end else begin
                     y_d = y_q + YW'(1);
                  end
               end else begin
                  x_d = x_q + XW'(1);
               end
            end else if (wb_m.err || wb_m.rty) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q;
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (!push && pop) begin
         level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge wb_m.clk) begin
      if (wb_m.rst) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         adr_q    <= BASE_ADR;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         adr_q    <= adr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; a write during reset lands in a flushed FIFO.
   always_ff @(posedge wb_m.clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign wb_m.cyc = (state_q == REQ);
   assign wb_m.stb = (state_q == REQ);
   assign wb_m.we  = 1'b0;
   assign wb_m.sel = 4'hF;
   assign wb_m.ms  = '0;
   assign wb_m.adr = adr_q;

   assign pix_valid                   = (level_q != '0);
   assign {pix_sof, pix_eol, pix_data} = mem_q[rd_ptr_q];
   assign fifo_level                  = level_q;

endmodule

// File: tb/tb_wb_frame_reader.sv
// tb_wb_frame_reader: randomized self-checking bench for wb_frame_reader
// (HDISP=4, VDISP=2, BASE_ADR=0x100, FIFO_DEPTH=16). A pixel-index queue
// models the FIFO, a Wishbone slave with random latency/err/rty serves a
// random 8-word memory, and every cycle the bus and stream are compared.
module tb_wb_frame_reader;

   localparam int unsigned HD    = 4;
   localparam int unsigned VD    = 2;
   localparam int unsigned NPIX  = HD * VD;
   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] BASE  = 32'h100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        pix_ready = 1'b0;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_sof;
   logic        pix_eol;
   logic [4:0]  fifo_level;

   logic [31:0] mem [NPIX];

   // knobs written by the sequencer, read by the slave/model process
   int unsigned k_ready_pct = 100;
   int unsigned k_en_pct    = 100;
   int unsigned k_lat_min   = 1;
   int unsigned k_lat_max   = 1;
   int unsigned k_err_pct   = 0;
   int unsigned k_rst_pml   = 0;
   bit          k_rst_req   = 1'b1;
   bit          k_err_once  = 1'b0;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   wshb_if bus (.clk(clk), .rst(rst));

   wb_frame_reader #(
      .HDISP(HD),
      .VDISP(VD),
      .BASE_ADR(BASE),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .wb_m(bus),
      .en(en),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_sof(pix_sof),
      .pix_eol(pix_eol),
      .fifo_level(fifo_level)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_req(input logic [31:0] a, input bit match_adr, input int unsigned limit,
                           input string tag);
      bit hit = 1'b0;
      for (int unsigned i = 0; i < limit && !hit; i++) begin
         @(negedge clk);
         hit = bus.stb && (!match_adr || bus.adr == a);
      end
      if (!hit) check(tag, 32'd0, 32'd1);
   endtask

   // Slave + reference model: one process, evaluated on every falling edge.
   initial begin : model
      int          q[$];
      int unsigned exp_k, cnt, lat, prev_lvl, idx;
      bit          prev_rst, prev_stb, prev_resp, prev_ack, prev_pop, prev_en;
      bit          err_done, exp_stb, rst_nx;
      int          head;
      exp_k = 0; cnt = 0; lat = 1; prev_lvl = 0;
      prev_rst = 1'b1; prev_stb = 1'b0; prev_resp = 1'b0; prev_ack = 1'b0;
      prev_pop = 1'b0; prev_en = 1'b0; err_done = 1'b0;
      for (int i = 0; i < int'(NPIX); i++) mem[i] = $urandom;
      bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0; bus.sm = '0;
      forever begin
         @(negedge clk);
         // apply what happened at the rising edge just passed
         if (prev_rst) begin
            q.delete();
            exp_k = 0;
         end else begin
            if (prev_pop) void'(q.pop_front());
            if (prev_ack) begin
               q.push_back(int'(exp_k));
               exp_k = (exp_k + 1) % NPIX;
            end
         end
         if (prev_rst)      exp_stb = 1'b0;
         else if (prev_stb) exp_stb = !prev_resp;
         else               exp_stb = prev_en && (prev_lvl < DEPTH);

         check("cyc", {31'd0, bus.cyc}, {31'd0, exp_stb});
         check("stb", {31'd0, bus.stb}, {31'd0, exp_stb});
         check("level", {27'd0, fifo_level}, q.size());
         check("valid", {31'd0, pix_valid}, {31'd0, q.size() != 0});
         if (prev_rst) check("rst_adr", bus.adr, BASE);
         if (q.size() != 0) begin
            head = q[0];
            check("pix_data", {8'd0, pix_data}, {8'd0, mem[head][23:0]});
            check("pix_sof", {31'd0, pix_sof}, {31'd0, head == 0});
            check("pix_eol", {31'd0, pix_eol}, {31'd0, (head % HD) == HD - 1});
         end
         if (bus.stb) begin
            check("adr", bus.adr, BASE + 4 * exp_k);
            if (cnt == 0) begin
               check("ctl", {27'd0, bus.we, bus.sel}, 32'h0F);
               check("ms", bus.ms, 32'd0);
            end
         end

         // drive inputs for the next rising edge
         rst_nx    = k_rst_req || ($urandom_range(999) < k_rst_pml);
         rst       = rst_nx;
         en        = $urandom_range(99) < k_en_pct;
         pix_ready = $urandom_range(99) < k_ready_pct;
         bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0;
         bus.sm  = $urandom;
         idx     = ((bus.adr - BASE) >> 2) % NPIX;
         if (bus.stb && rst_nx) begin
            bus.ack = 1'b1;              // must be discarded by the reset
            bus.sm  = mem[idx];
            cnt     = 0;
         end else if (bus.stb) begin
            if (cnt >= lat) begin
               if (k_err_once && !err_done && bus.adr == BASE + 32'h8) begin
                  bus.err  = 1'b1;
                  err_done = 1'b1;
               end else if ($urandom_range(99) < k_err_pct) begin
                  if ($urandom_range(1) == 0) bus.err = 1'b1;
                  else                        bus.rty = 1'b1;
               end else begin
                  bus.ack = 1'b1;
                  bus.sm  = mem[idx];
                  if ($urandom_range(9) == 0) bus.err = 1'b1;
               end
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
            lat = k_lat_min + $urandom_range(k_lat_max - k_lat_min);
         end

         prev_pop  = (q.size() != 0) && pix_ready;
         prev_lvl  = q.size();
         prev_resp = bus.stb && (bus.ack || bus.err || bus.rty);
         prev_ack  = bus.stb && bus.ack && !rst_nx;
         prev_stb  = bus.stb;
         prev_rst  = rst_nx;
         prev_en   = en;
      end
   end

   initial begin : sequencer
      repeat (3) @(negedge clk);
      #1 k_rst_req = 1'b0;

      // BlockRAM-style one-cycle-late ack, free-flowing consumer
      repeat (60) @(negedge clk);

      // consumer stalled: FIFO fills to DEPTH and the master goes quiet
      #1 k_ready_pct = 0;
      repeat (80) @(negedge clk);
      check("full_level", {27'd0, fifo_level}, DEPTH);
      check("full_idle", {31'd0, bus.cyc}, 32'd0);
      #1 k_ready_pct = 100;
      repeat (40) @(negedge clk);

      // combinational ack over several frames
      #1 k_lat_min = 0; k_lat_max = 0;
      repeat (100) @(negedge clk);

      // err on the first access to 0x108, then normal acks
      #1 k_lat_min = 1; k_lat_max = 1; k_err_once = 1'b1;
      repeat (60) @(negedge clk);

      // en dropped while 0x10C is outstanding
      #1 k_lat_min = 3; k_lat_max = 3;
      wait_req(BASE + 32'hC, 1'b1, 200, "reach_10c");
      #1 k_en_pct = 0;
      repeat (20) @(negedge clk);
      check("en_off_idle", {31'd0, bus.cyc}, 32'd0);
      #1 k_en_pct = 100;
      wait_req(32'd0, 1'b0, 10, "resume_req");
      check("resume_adr", bus.adr, BASE + 32'h10);

      // reset while waiting for ack at 0x114
      #1 k_lat_min = 6; k_lat_max = 6;
      wait_req(BASE + 32'h14, 1'b1, 300, "reach_114");
      #1 k_rst_req = 1'b1;
      @(negedge clk);
      #1 k_rst_req = 1'b0;
      @(negedge clk);
      check("rst_cyc", {31'd0, bus.cyc}, 32'd0);
      check("rst_valid", {31'd0, pix_valid}, 32'd0);
      wait_req(32'd0, 1'b0, 10, "rst_resume");
      check("rst_first_adr", bus.adr, BASE);

      // fully randomized traffic
      #1 k_lat_min = 0; k_lat_max = 3; k_ready_pct = 70; k_en_pct = 90;
      k_err_pct = 10; k_rst_pml = 3;
      repeat (4000) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
